// File: rtl/fifo_read_checker.sv
// Reads CHECK_LEN words from a FIFO and compares them against an incrementing
// sequence starting at SEED; reports counts, first mismatch and last word seen.
module fifo_read_checker #(
  parameter int WIDTH     = 8,
  parameter int CHECK_LEN = 63,
  parameter int GAP       = 0,
  parameter int SEED      = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             fifo_rd_en,
  output logic             busy,
  output logic             done,
  output logic [15:0]      word_cnt,
  output logic [15:0]      err_cnt,
  output logic             err_flag,
  output logic [WIDTH-1:0] first_err_data,
  output logic [WIDTH-1:0] last_data
);

  localparam logic [15:0]      LAST_IDX = 16'(CHECK_LEN - 1);
  localparam logic [3:0]       GAP_LD   = 4'(GAP);
  localparam logic [WIDTH-1:0] SEED_V   = WIDTH'(SEED);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state;
  logic [3:0]       gap_cnt;
  logic [15:0]      rd_issued;
  logic             rd_valid;
  logic [WIDTH-1:0] expected;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      fifo_rd_en     <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      word_cnt       <= '0;
      err_cnt        <= '0;
      err_flag       <= 1'b0;
      first_err_data <= '0;
      last_data      <= '0;
      gap_cnt        <= '0;
      rd_issued      <= '0;
      rd_valid       <= 1'b0;
      expected       <= '0;
    end else begin
      fifo_rd_en <= 1'b0;
      rd_valid   <= fifo_rd_en;

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= RUN;
            busy           <= 1'b1;
            done           <= 1'b0;
            word_cnt       <= '0;
            err_cnt        <= '0;
            err_flag       <= 1'b0;
            first_err_data <= '0;
            expected       <= SEED_V;
            gap_cnt        <= '0;
            rd_issued      <= '0;
          end
        end
        RUN: begin
          // Staying in RUN implies fewer than CHECK_LEN strobes issued so far.
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 4'd1;
          end else if (!fifo_empty) begin
            fifo_rd_en <= 1'b1;
            gap_cnt    <= GAP_LD;
            rd_issued  <= rd_issued + 16'd1;
            if (rd_issued == LAST_IDX) state <= DRAIN;
          end
        end
        default: ;
      endcase

      if (rd_valid && busy) begin
        last_data <= fifo_rd_data;
        word_cnt  <= word_cnt + 16'd1;
        expected  <= expected + WIDTH'(1);
        if (fifo_rd_data != expected) begin
          if (err_cnt != '1) err_cnt <= err_cnt + 16'd1;
          if (!err_flag) begin
            err_flag       <= 1'b1;
            first_err_data <= fifo_rd_data;
          end
        end
        if (state == DRAIN && word_cnt == LAST_IDX) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_read_checker.sv
// Directed bench for fifo_read_checker: three instances (default, GAP=3,
// SEED=250 wrap) each fed by a small behavioural FIFO.
module tb_fifo_read_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a        [3];
  logic       fifo_empty_a   [3];
  logic [7:0] fifo_rd_data_a [3];
  logic       fifo_rd_en_a   [3];
  logic       busy_a         [3];
  logic       done_a         [3];
  logic [15:0] word_cnt_a    [3];
  logic [15:0] err_cnt_a     [3];
  logic       err_flag_a     [3];
  logic [7:0] first_err_a    [3];
  logic [7:0] last_data_a    [3];

  always #5 clk = ~clk;

  fifo_read_checker #(.WIDTH(8), .CHECK_LEN(63), .GAP(0), .SEED(0)) u_dut (
    .clk(clk), .rst(rst), .start(start_a[0]), .fifo_empty(fifo_empty_a[0]),
    .fifo_rd_data(fifo_rd_data_a[0]), .fifo_rd_en(fifo_rd_en_a[0]),
    .busy(busy_a[0]), .done(done_a[0]), .word_cnt(word_cnt_a[0]),
    .err_cnt(err_cnt_a[0]), .err_flag(err_flag_a[0]),
    .first_err_data(first_err_a[0]), .last_data(last_data_a[0]));

  fifo_read_checker #(.WIDTH(8), .CHECK_LEN(12), .GAP(3), .SEED(0)) u_gap (
    .clk(clk), .rst(rst), .start(start_a[1]), .fifo_empty(fifo_empty_a[1]),
    .fifo_rd_data(fifo_rd_data_a[1]), .fifo_rd_en(fifo_rd_en_a[1]),
    .busy(busy_a[1]), .done(done_a[1]), .word_cnt(word_cnt_a[1]),
    .err_cnt(err_cnt_a[1]), .err_flag(err_flag_a[1]),
    .first_err_data(first_err_a[1]), .last_data(last_data_a[1]));

  fifo_read_checker #(.WIDTH(8), .CHECK_LEN(10), .GAP(0), .SEED(250)) u_wrap (
    .clk(clk), .rst(rst), .start(start_a[2]), .fifo_empty(fifo_empty_a[2]),
    .fifo_rd_data(fifo_rd_data_a[2]), .fifo_rd_en(fifo_rd_en_a[2]),
    .busy(busy_a[2]), .done(done_a[2]), .word_cnt(word_cnt_a[2]),
    .err_cnt(err_cnt_a[2]), .err_flag(err_flag_a[2]),
    .first_err_data(first_err_a[2]), .last_data(last_data_a[2]));

  // Behavioural FIFOs: registered read data one cycle after an accepted read.
  logic [7:0]  mem [3][256];
  int unsigned wptr [3] = '{0, 0, 0};
  int unsigned rptr [3] = '{0, 0, 0};
  logic        flush [3];

  always_comb
    for (int i = 0; i < 3; i++) fifo_empty_a[i] = (wptr[i] == rptr[i]);

  always @(posedge clk)
    for (int i = 0; i < 3; i++) begin
      if (flush[i]) rptr[i] <= wptr[i];
      else if (fifo_rd_en_a[i] && !fifo_empty_a[i]) begin
        fifo_rd_data_a[i] <= mem[i][rptr[i][7:0]];
        rptr[i]           <= rptr[i] + 1;
      end
    end

  // Strobe monitor: count, minimum spacing, strobes issued against an empty FIFO.
  int   cyc = 0;
  int   strobe_cnt  [3] = '{0, 0, 0};
  int   last_strobe [3] = '{-1, -1, -1};
  int   min_space   [3] = '{1000, 1000, 1000};
  int   empty_viol  [3] = '{0, 0, 0};
  logic prev_empty  [3] = '{1'b1, 1'b1, 1'b1};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 3; i++) begin
      if (fifo_rd_en_a[i]) begin
        strobe_cnt[i]  <= strobe_cnt[i] + 1;
        last_strobe[i] <= cyc;
        if (last_strobe[i] >= 0 && cyc - last_strobe[i] < min_space[i])
          min_space[i] <= cyc - last_strobe[i];
        if (prev_empty[i]) empty_viol[i] <= empty_viol[i] + 1;
      end
      prev_empty[i] <= fifo_empty_a[i];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] v);
    mem[i][wptr[i][7:0]] = v;
    wptr[i] = wptr[i] + 1;
  endtask

  task automatic start_run(input int i);
    start_a[i] = 1'b1;
    @(negedge clk);
    start_a[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, output int n);
    n = 0;
    while (!done_a[i] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("done_reached", done_a[i], 1);
  endtask

  int n, base;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_a[i] = 1'b0;
      flush[i]   = 1'b0;
    end
    repeat (3) @(negedge clk);

    check("rst_rd_en", fifo_rd_en_a[0], 0);
    check("rst_busy", busy_a[0], 0);
    check("rst_done", done_a[0], 0);
    check("rst_word_cnt", word_cnt_a[0], 0);
    check("rst_err_cnt", err_cnt_a[0], 0);
    check("rst_err_flag", err_flag_a[0], 0);
    check("rst_first_err", first_err_a[0], 0);
    check("rst_last_data", last_data_a[0], 0);
    rst = 1'b0;
    @(negedge clk);

    // Clean back-to-back run of 63 words.
    for (int v = 0; v < 63; v++) push(0, 8'(v));
    base = strobe_cnt[0];
    start_run(0);
    check("r1_busy", busy_a[0], 1);
    wait_done(0, n);
    check("r1_latency", n, 65);
    check("r1_strobes", strobe_cnt[0] - base, 63);
    check("r1_word_cnt", word_cnt_a[0], 63);
    check("r1_err_cnt", err_cnt_a[0], 0);
    check("r1_err_flag", err_flag_a[0], 0);
    check("r1_last_data", last_data_a[0], 62);
    check("r1_busy_end", busy_a[0], 0);
    repeat (5) @(negedge clk);
    check("r1_hold_done", done_a[0], 1);
    check("r1_hold_words", word_cnt_a[0], 63);

    // Word 10 corrupted; a start pulse mid-run must be ignored.
    for (int v = 0; v < 63; v++) push(0, (v == 10) ? 8'hAA : 8'(v));
    base = strobe_cnt[0];
    start_run(0);
    repeat (10) @(negedge clk);
    check("r2_busy_mid", busy_a[0], 1);
    start_run(0);
    wait_done(0, n);
    check("r2_strobes", strobe_cnt[0] - base, 63);
    check("r2_word_cnt", word_cnt_a[0], 63);
    check("r2_err_cnt", err_cnt_a[0], 1);
    check("r2_err_flag", err_flag_a[0], 1);
    check("r2_first_err", first_err_a[0], 8'hAA);
    check("r2_last_data", last_data_a[0], 62);

    // Start from DONE clears the error status.
    for (int v = 0; v < 63; v++) push(0, 8'(v));
    start_run(0);
    check("r3_clr_busy", busy_a[0], 1);
    check("r3_clr_done", done_a[0], 0);
    check("r3_clr_words", word_cnt_a[0], 0);
    check("r3_clr_err_cnt", err_cnt_a[0], 0);
    check("r3_clr_err_flag", err_flag_a[0], 0);
    check("r3_clr_first_err", first_err_a[0], 0);
    wait_done(0, n);
    check("r3_word_cnt", word_cnt_a[0], 63);
    check("r3_err_cnt", err_cnt_a[0], 0);

    // GAP=3 with a backlog of 4 words, then a writer slower than the reader.
    for (int v = 0; v < 4; v++) push(1, 8'(v));
    base = strobe_cnt[1];
    start_run(1);
    for (int v = 4; v < 12; v++) begin
      repeat (8) @(negedge clk);
      push(1, 8'(v));
    end
    wait_done(1, n);
    check("gap_strobes", strobe_cnt[1] - base, 12);
    check("gap_min_space", min_space[1], 4);
    check("gap_empty_viol", empty_viol[1], 0);
    check("gap_word_cnt", word_cnt_a[1], 12);
    check("gap_err_cnt", err_cnt_a[1], 0);
    check("gap_last_data", last_data_a[1], 11);

    // SEED=250: expected value wraps 255 -> 0.
    for (int k = 0; k < 10; k++) push(2, 8'(250 + k));
    start_run(2);
    wait_done(2, n);
    check("wrap_word_cnt", word_cnt_a[2], 10);
    check("wrap_err_cnt", err_cnt_a[2], 0);
    check("wrap_err_flag", err_flag_a[2], 0);
    check("wrap_last_data", last_data_a[2], 3);

    // Reset mid-run with a read in flight.
    for (int v = 0; v < 63; v++) push(0, 8'(v));
    start_run(0);
    n = 0;
    while (word_cnt_a[0] != 16'd20 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach20", word_cnt_a[0], 20);
    check("abort_inflight", fifo_rd_en_a[0], 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_rd_en", fifo_rd_en_a[0], 0);
    check("abort_busy", busy_a[0], 0);
    check("abort_done", done_a[0], 0);
    check("abort_word_cnt", word_cnt_a[0], 0);
    check("abort_last_data", last_data_a[0], 0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_after_words", word_cnt_a[0], 0);
    check("abort_after_last", last_data_a[0], 0);
    flush[0] = 1'b1;
    @(negedge clk);
    flush[0] = 1'b0;
    for (int v = 0; v < 63; v++) push(0, 8'(v));
    start_run(0);
    wait_done(0, n);
    check("rerun_word_cnt", word_cnt_a[0], 63);
    check("rerun_err_cnt", err_cnt_a[0], 0);
    check("rerun_last_data", last_data_a[0], 62);

    // Reset wins over a simultaneous start.
    rst = 1'b1;
    start_a[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start_a[0] = 1'b0;
    check("rst_prio_busy", busy_a[0], 0);
    check("rst_prio_done", done_a[0], 0);
    @(negedge clk);
    check("rst_prio_idle", busy_a[0], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
